ly_hit_stretcher: RTL and testbench



---
 rtl/ly_hit_stretcher.sv | 82 ++++++++
 tb/tb_ly_hit_stretcher.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ly_hit_stretcher.sv
`default_nettype none
// ============================================================================
// Module      : ly_hit_stretcher
// Description : Per-layer hit stretcher. Extends each one-cycle layer pulse
//               to a programmable number of cycles, freezes on trig_stop,
//               and keeps a saturating count of accepted hits.
// Revision    : 1.0 - initial release
// ============================================================================
module ly_hit_stretcher #(
    parameter int NCH = 48,
    parameter int CW  = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] lyr,
    input  logic [CW-1:0]  width_cfg,
    input  logic           trig_stop,
    output logic [NCH-1:0] lys,
    output logic           lys_any,
    output logic [7:0]     hit_cnt
);

    // Popcount must hold NCH; the sum is one bit wider than the wider of the
    // popcount and the 8-bit counter so the saturation test never overflows.
    localparam int c_POP_W = $clog2(NCH + 1);
    localparam int c_SUM_W = ((c_POP_W > 8) ? c_POP_W : 8) + 1;

    logic [NCH-1:0]     w_accepted;
    logic [c_POP_W-1:0] w_pop;
    logic [c_SUM_W-1:0] w_sum;
    logic [7:0]         w_hit_next;
    logic [7:0]         r_hit_cnt;

    // One down-counter per channel; the output is decoded straight from the
    // register so lys carries no logic depth beyond a compare-to-zero.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CW-1:0] r_cnt;

        // Reset clears, freeze holds, a new pulse (re)loads, otherwise count down.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (trig_stop) begin
                r_cnt <= r_cnt;
            end else if (lyr[i]) begin
                r_cnt <= width_cfg;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end

        assign lys[i] = (r_cnt != '0);
    end

    assign lys_any = |lys;

    // Hits that arrive during a freeze are dropped, so they must not be counted.
    assign w_accepted = trig_stop ? '0 : lyr;

    // Number of hits accepted at this edge, then the saturated running total.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NCH; i++) begin
            w_pop = w_pop + c_POP_W'(w_accepted[i]);
        end
        w_sum      = c_SUM_W'(r_hit_cnt) + c_SUM_W'(w_pop);
        w_hit_next = (w_sum > c_SUM_W'(255)) ? 8'hFF : w_sum[7:0];
    end

    // Accepted-hit counter; never wraps past 255.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hit_cnt <= 8'd0;
        end else begin
            r_hit_cnt <= w_hit_next;
        end
    end

    assign hit_cnt = r_hit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ly_hit_stretcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_ly_hit_stretcher
// Description : Directed self-checking bench for ly_hit_stretcher.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ly_hit_stretcher;

    localparam int NCH = 48;
    localparam int CW  = 3;

    logic           clk;
    logic           rst_n;
    logic [NCH-1:0] lyr;
    logic [CW-1:0]  width_cfg;
    logic           trig_stop;
    logic [NCH-1:0] lys;
    logic           lys_any;
    logic [7:0]     hit_cnt;

    int checks;
    int errors;

    ly_hit_stretcher #(.NCH(NCH), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lyr       (lyr),
        .width_cfg (width_cfg),
        .trig_stop (trig_stop),
        .lys       (lys),
        .lys_any   (lys_any),
        .hit_cnt   (hit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; lyr = '0; trig_stop = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; lyr = '1; trig_stop = 1'b1; width_cfg = 3'd7;
        step();
        step();
        checks++;
        if (lys !== '0) begin errors++; $display("FAIL reset_lys: got %h expected %h", lys, 48'h0); end
        checks++;
        if (lys_any !== 1'b0) begin errors++; $display("FAIL reset_lys_any: got %b expected 0", lys_any); end
        checks++;
        if (hit_cnt !== 8'd0) begin errors++; $display("FAIL reset_hit_cnt: got %0d expected 0", hit_cnt); end
        rst_n = 1'b1; lyr = '0; trig_stop = 1'b0;
        step();
        checks++;
        if (lys !== '0 || hit_cnt !== 8'd0) begin
            errors++; $display("FAIL reset_idle: lys %h hit_cnt %0d expected 0 and 0", lys, hit_cnt);
        end
    endtask

    task automatic test_single();
        logic [NCH-1:0] bit5;
        bit5 = '0; bit5[5] = 1'b1;
        apply_reset();
        width_cfg = 3'd3; lyr = bit5;
        step();
        lyr = '0;
        // High after edges n, n+1, n+2 (cnt 3,2,1), low after n+3.
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (lys !== bit5 || lys_any !== 1'b1) begin
                errors++; $display("FAIL single_high[%0d]: lys %h any %b expected %h 1", k, lys, lys_any, bit5);
            end
            step();
        end
        checks++;
        if (lys !== '0 || lys_any !== 1'b0) begin
            errors++; $display("FAIL single_end: lys %h any %b expected 0 0", lys, lys_any);
        end
        checks++;
        if (hit_cnt !== 8'd1) begin errors++; $display("FAIL single_hit_cnt: got %0d expected 1", hit_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [NCH-1:0] bit0;
        bit0 = '0; bit0[0] = 1'b1;
        apply_reset();
        width_cfg = 3'd4; lyr = bit0;
        step();
        // Edge n loads 4, edge n+1 gives 3, edge n+2 reloads 4, then 3,2,1:
        // high after edges n..n+5 (6 cycles), low after n+6.
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (lys !== bit0) begin
                errors++; $display("FAIL retrig_high[%0d]: lys %h expected %h", k, lys, bit0);
            end
            lyr = (k == 1) ? bit0 : '0;
            step();
        end
        checks++;
        if (lys !== '0) begin errors++; $display("FAIL retrig_end: lys %h expected 0", lys); end
        checks++;
        if (hit_cnt !== 8'd2) begin errors++; $display("FAIL retrig_hit_cnt: got %0d expected 2", hit_cnt); end
    endtask

    task automatic test_freeze();
        logic [NCH-1:0] bit47;
        bit47 = '0; bit47[47] = 1'b1;
        apply_reset();
        width_cfg = 3'd5; lyr = bit47;
        step();                     // edge n: cnt 5
        lyr = '0;
        step();                     // edge n+1: cnt 4
        trig_stop = 1'b1;
        // Edges n+2..n+11 frozen at 4; the pulse at n+5 is dropped.
        for (int e = 2; e <= 11; e++) begin
            lyr = (e == 5) ? bit47 : '0;
            step();
            checks++;
            if (lys !== bit47 || lys_any !== 1'b1) begin
                errors++; $display("FAIL freeze_hold[%0d]: lys %h any %b expected %h 1", e, lys, lys_any, bit47);
            end
        end
        checks++;
        if (hit_cnt !== 8'd1) begin errors++; $display("FAIL freeze_hit_hold: got %0d expected 1", hit_cnt); end
        trig_stop = 1'b0; lyr = '0;
        // Released from cnt 4: 3,2,1 after edges n+12..n+14, then 0.
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (lys !== bit47) begin
                errors++; $display("FAIL freeze_release[%0d]: lys %h expected %h", k, lys, bit47);
            end
        end
        step();
        checks++;
        if (lys !== '0 || lys_any !== 1'b0) begin
            errors++; $display("FAIL freeze_end: lys %h any %b expected 0 0", lys, lys_any);
        end
        checks++;
        if (hit_cnt !== 8'd1) begin errors++; $display("FAIL freeze_hit_cnt: got %0d expected 1", hit_cnt); end
    endtask

    task automatic test_mask_saturate();
        int exp_cnt;
        apply_reset();
        width_cfg = 3'd0;
        exp_cnt = 0;
        // 48, 96, 144, 192, 240, then saturate at 255.
        for (int k = 1; k <= 6; k++) begin
            lyr = '1;
            step();
            lyr = '0;
            exp_cnt = (48 * k > 255) ? 255 : 48 * k;
            checks++;
            if (lys !== '0 || lys_any !== 1'b0) begin
                errors++; $display("FAIL mask_lys[%0d]: lys %h any %b expected 0 0", k, lys, lys_any);
            end
            checks++;
            if (hit_cnt !== exp_cnt[7:0]) begin
                errors++; $display("FAIL mask_hit_cnt[%0d]: got %0d expected %0d", k, hit_cnt, exp_cnt);
            end
        end
        lyr = '1;
        step();
        lyr = '0;
        step();
        checks++;
        if (hit_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d expected 255", hit_cnt); end
    endtask

    task automatic test_width_change();
        logic [NCH-1:0] bit10;
        bit10 = '0; bit10[10] = 1'b1;
        apply_reset();
        width_cfg = 3'd2; lyr = bit10;
        step();
        lyr = '0; width_cfg = 3'd7;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (lys !== bit10) begin errors++; $display("FAIL wchg_old[%0d]: lys %h expected %h", k, lys, bit10); end
            step();
        end
        checks++;
        if (lys !== '0) begin errors++; $display("FAIL wchg_old_end: lys %h expected 0", lys); end
        lyr = bit10;
        step();
        lyr = '0;
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (lys !== bit10) begin errors++; $display("FAIL wchg_new[%0d]: lys %h expected %h", k, lys, bit10); end
            step();
        end
        checks++;
        if (lys !== '0) begin errors++; $display("FAIL wchg_new_end: lys %h expected 0", lys); end
        checks++;
        if (hit_cnt !== 8'd2) begin errors++; $display("FAIL wchg_hit_cnt: got %0d expected 2", hit_cnt); end
    endtask

    task automatic test_independent_and_midreset();
        logic [NCH-1:0] b3;
        logic [NCH-1:0] b20;
        logic [NCH-1:0] both;
        b3 = '0; b3[3] = 1'b1;
        b20 = '0; b20[20] = 1'b1;
        both = b3 | b20;
        apply_reset();
        width_cfg = 3'd2; lyr = b3;
        step();                     // ch3 = 2
        width_cfg = 3'd6; lyr = b20;
        step();                     // ch3 = 1, ch20 = 6
        lyr = '0;
        checks++;
        if (lys !== both) begin errors++; $display("FAIL indep_both: lys %h expected %h", lys, both); end
        step();                     // ch3 = 0, ch20 = 5
        checks++;
        if (lys !== b20) begin errors++; $display("FAIL indep_ch20: lys %h expected %h", lys, b20); end
        rst_n = 1'b0; trig_stop = 1'b1; lyr = '1;
        step();
        checks++;
        if (lys !== '0 || lys_any !== 1'b0 || hit_cnt !== 8'd0) begin
            errors++; $display("FAIL midreset: lys %h any %b hit %0d expected 0 0 0", lys, lys_any, hit_cnt);
        end
        rst_n = 1'b1; trig_stop = 1'b0; lyr = '0;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0; lyr = '0; width_cfg = '0; trig_stop = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_freeze();
        test_mask_saturate();
        test_width_change();
        test_independent_and_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
